// File: rtl/pio_keys_in.sv
// pio_keys_in: Avalon-MM input PIO for the watch keys/switches (sync, debounce, edge capture, maskable IRQ).
// Define PIO_KEYS_DEBOUNCE_EN to build the per-bit debounce counters; otherwise DATA follows the synchroniser.
module pio_keys_in #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [1:0] EDGE_SEL = 2'(EDGE_TYPE);

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_param_check
    $error("pio_keys_in: illegal parameter value");
  end

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_irqmask;
  logic [WIDTH-1:0] r_edgecap;

  logic             w_wr_en;
  logic [WIDTH-1:0] w_accept;
  logic [WIDTH-1:0] w_data_nxt;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_edgecap_nxt;
  logic             w_unused_wd;

  assign w_wr_en     = chipselect & ~write_n;
  assign w_unused_wd = ^writedata;

  // Two-flop synchroniser; reset to the released (all-ones) key level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= in_port;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PIO_KEYS_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt [WIDTH];

  // A differing level is accepted only after it has persisted for the full count.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = (r_sync2[i] != r_data[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  // Per-bit counters: any return to the DATA level throws away accumulated credit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_sync2[i] == r_data[i]) || (r_cnt[i] == CNT_MAX)) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign w_accept = r_sync2 ^ r_data;
`endif

  // Next DATA value and the edge-capture set/clear terms.
  always_comb begin
    w_data_nxt = (r_data & ~w_accept) | (r_sync2 & w_accept);
    w_set      = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (EDGE_SEL)
        2'd0:    w_set[i] = w_accept[i] & r_sync2[i] & ~r_data[i];
        2'd1:    w_set[i] = w_accept[i] & ~r_sync2[i] & r_data[i];
        default: w_set[i] = w_accept[i];
      endcase
    end
    if (w_wr_en && (address == 2'd3)) begin
      w_clr = writedata[WIDTH-1:0];
    end else begin
      w_clr = '0;
    end
    // A capture on the same edge as its W1C must survive.
    w_edgecap_nxt = (r_edgecap & ~w_clr) | w_set;
  end

  // DATA, IRQMASK and EDGECAP registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_data    <= '1;
      r_irqmask <= '0;
      r_edgecap <= '0;
    end else begin
      r_data    <= w_data_nxt;
      r_edgecap <= w_edgecap_nxt;
      if (w_wr_en && (address == 2'd2)) begin
        r_irqmask <= writedata[WIDTH-1:0];
      end else begin
        r_irqmask <= r_irqmask;
      end
    end
  end

  // Zero-latency read mux; chipselect is deliberately ignored.
  always_comb begin
    readdata = 32'h0000_0000;
    case (address)
      2'd0:    readdata = 32'(r_data);
      2'd2:    readdata = 32'(r_irqmask);
      2'd3:    readdata = 32'(r_edgecap);
      default: readdata = 32'h0000_0000;
    endcase
  end

  assign irq = |(r_edgecap & r_irqmask);

endmodule

// File: tb/tb_pio_keys_in.sv
// Self-checking bench for pio_keys_in: table-driven vectors with an expectation queue plus
// hand-written reset, glitch, collision, any-edge and mid-debounce reset sequences.
module tb_pio_keys_in;

`ifdef PIO_KEYS_DEBOUNCE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs_a, cs_b;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a;
  logic [1:0]  in_b;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  always #5 clk = ~clk;

  pio_keys_in #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a),
    .write_n(write_n), .writedata(writedata), .in_port(in_a),
    .readdata(rd_a), .irq(irq_a)
  );

  pio_keys_in #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_b),
    .write_n(write_n), .writedata(writedata), .in_port(in_b),
    .readdata(rd_b), .irq(irq_b)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  typedef struct {
    string       name;
    logic [3:0]  pins;
    int          idle;
    bit          do_wr;
    logic [1:0]  wa;
    logic [31:0] wd;
    logic [3:0]  e_data;
    logic [3:0]  e_cap;
    bit          e_irq;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string n, input logic [31:0] e);
    sb.push_back('{n, e});
  endtask

  task automatic compare_next(input logic [31:0] act);
    exp_t x;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with no expectation queued", act);
    end else begin
      x = sb.pop_front();
      if (act !== x.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", x.name, act, x.exp);
      end
    end
  endtask

  task automatic read_reg(input bit sel_b, input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = sel_b ? rd_b : rd_a;
  endtask

  task automatic chk_reg(input bit sel_b, input logic [1:0] a, input string n, input logic [31:0] e);
    logic [31:0] v;
    expect_val(n, e);
    read_reg(sel_b, a, v);
    compare_next(v);
  endtask

  task automatic chk_irq(input bit sel_b, input string n, input bit e);
    expect_val(n, {31'd0, e});
    compare_next({31'd0, (sel_b ? irq_b : irq_a)});
  endtask

  task automatic bus_write(input bit sel_b, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = ~sel_b;
    cs_b      = sel_b;
    tick();
    cs_a    = 1'b0;
    cs_b    = 1'b0;
    write_n = 1'b1;
  endtask

  initial begin
    logic [31:0] v;
    reset_n = 1'b0; address = 2'd0; cs_a = 1'b0; cs_b = 1'b0;
    write_n = 1'b1; writedata = 32'd0; in_a = 4'h0; in_b = 2'b11;

    // name, pins, idle, do_wr, wa, wd, e_data, e_cap, e_irq
    vecs[0]  = '{"clear_all",    4'h0, 0,   1'b1, 2'd3, 32'h0000_000F, 4'h0, 4'h0, 1'b0};
    vecs[1]  = '{"rise_pending", 4'hF, LAT, 1'b0, 2'd0, 32'h0,         4'h0, 4'h0, 1'b0};
    vecs[2]  = '{"rise_accept",  4'hF, 1,   1'b0, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0};
    vecs[3]  = '{"fall_pending", 4'hE, LAT, 1'b0, 2'd0, 32'h0,         4'hF, 4'h0, 1'b0};
    vecs[4]  = '{"fall_accept",  4'hE, 1,   1'b0, 2'd0, 32'h0,         4'hE, 4'h1, 1'b0};
    vecs[5]  = '{"mask_on",      4'hE, 0,   1'b1, 2'd2, 32'h0000_0001, 4'hE, 4'h1, 1'b1};
    vecs[6]  = '{"w1c_other",    4'hE, 0,   1'b1, 2'd3, 32'h0000_0002, 4'hE, 4'h1, 1'b1};
    vecs[7]  = '{"w1c_clear",    4'hE, 0,   1'b1, 2'd3, 32'h0000_0001, 4'hE, 4'h0, 1'b0};
    vecs[8]  = '{"b1_pending",   4'hC, LAT, 1'b0, 2'd0, 32'h0,         4'hE, 4'h0, 1'b0};
    vecs[9]  = '{"collision",    4'hC, 0,   1'b1, 2'd3, 32'h0000_0002, 4'hC, 4'h2, 1'b0};
    vecs[10] = '{"mask_b1",      4'hC, 0,   1'b1, 2'd2, 32'h0000_0003, 4'hC, 4'h2, 1'b1};
    vecs[11] = '{"mask_off",     4'hC, 0,   1'b1, 2'd2, 32'h0000_0000, 4'hC, 4'h2, 1'b0};
    vecs[12] = '{"w1c_b1",       4'hC, 0,   1'b1, 2'd3, 32'h0000_0002, 4'hC, 4'h0, 1'b0};
    vecs[13] = '{"data_ro",      4'hC, 0,   1'b1, 2'd0, 32'hFFFF_FFFF, 4'hC, 4'h0, 1'b0};

    // Reset with keys held low, then the held level is debounced as a falling edge.
    repeat (3) tick();
    chk_reg(1'b0, 2'd0, "rst_data", 32'h0000_000F);
    chk_reg(1'b0, 2'd2, "rst_mask", 32'h0);
    chk_reg(1'b0, 2'd3, "rst_cap",  32'h0);
    chk_irq(1'b0, "rst_irq", 1'b0);
    chk_reg(1'b1, 2'd0, "rst_b_data", 32'h0000_0003);
    reset_n = 1'b1;
    repeat (LAT) tick();
    chk_reg(1'b0, 2'd0, "post_rst_hold", 32'h0000_000F);
    tick();
    chk_reg(1'b0, 2'd0, "post_rst_data", 32'h0);
    chk_reg(1'b0, 2'd3, "post_rst_cap",  32'h0000_000F);

    for (int i = 0; i < 14; i++) begin
      in_a = vecs[i].pins;
      expect_val({vecs[i].name, "_data"}, 32'(vecs[i].e_data));
      expect_val({vecs[i].name, "_cap"},  32'(vecs[i].e_cap));
      expect_val({vecs[i].name, "_irq"},  {31'd0, vecs[i].e_irq});
      if (vecs[i].do_wr) bus_write(1'b0, vecs[i].wa, vecs[i].wd);
      else repeat (vecs[i].idle) tick();
      read_reg(1'b0, 2'd0, v); compare_next(v);
      read_reg(1'b0, 2'd3, v); compare_next(v);
      compare_next({31'd0, irq_a});
    end

    // Reserved address and upper bits.
    bus_write(1'b0, 2'd1, 32'hFFFF_FFFF);
    chk_reg(1'b0, 2'd1, "addr1_zero", 32'h0);
    bus_write(1'b0, 2'd2, 32'hFFFF_FFFF);
    chk_reg(1'b0, 2'd2, "mask_width", 32'h0000_000F);
    chk_irq(1'b0, "mask_all_nocap", 1'b0);
    bus_write(1'b0, 2'd2, 32'h0);

    // One-cycle glitch on bit3.
    in_a = 4'h4; tick(); in_a = 4'hC; tick();
    chk_reg(1'b0, 2'd0, "g1_e1", 32'h0000_000C);
    tick();
`ifdef PIO_KEYS_DEBOUNCE_EN
    chk_reg(1'b0, 2'd0, "g1_e2", 32'h0000_000C);
`else
    chk_reg(1'b0, 2'd0, "g1_e2", 32'h0000_0004);
`endif
    tick();
    chk_reg(1'b0, 2'd0, "g1_e3", 32'h0000_000C);
    repeat (4) tick();
`ifdef PIO_KEYS_DEBOUNCE_EN
    chk_reg(1'b0, 2'd3, "g1_cap", 32'h0);
`else
    chk_reg(1'b0, 2'd3, "g1_cap", 32'h0000_0008);
`endif
    bus_write(1'b0, 2'd3, 32'h0000_000F);

    // Three-cycle drop on bit2: one short of acceptance when debounced.
    in_a = 4'h8; repeat (3) tick();
`ifdef PIO_KEYS_DEBOUNCE_EN
    chk_reg(1'b0, 2'd0, "g3_mid", 32'h0000_000C);
`else
    chk_reg(1'b0, 2'd0, "g3_mid", 32'h0000_0008);
`endif
    in_a = 4'hC; repeat (3) tick();
    chk_reg(1'b0, 2'd0, "g3_end", 32'h0000_000C);
`ifdef PIO_KEYS_DEBOUNCE_EN
    chk_reg(1'b0, 2'd3, "g3_cap", 32'h0);
`else
    chk_reg(1'b0, 2'd3, "g3_cap", 32'h0000_0004);
`endif
    bus_write(1'b0, 2'd3, 32'h0000_000F);

    // Any-edge instance: bit1 1->0 then 0->1, cleared in between.
    in_b = 2'b01; repeat (8) tick();
    chk_reg(1'b1, 2'd0, "b_fall_data", 32'h0000_0001);
    chk_reg(1'b1, 2'd3, "b_fall_cap",  32'h0000_0002);
    bus_write(1'b1, 2'd3, 32'h0000_0002);
    chk_reg(1'b1, 2'd3, "b_cleared", 32'h0);
    in_b = 2'b11; repeat (8) tick();
    chk_reg(1'b1, 2'd0, "b_rise_data", 32'h0000_0003);
    chk_reg(1'b1, 2'd3, "b_rise_cap",  32'h0000_0002);
    bus_write(1'b1, 2'd2, 32'hFFFF_FFFF);
    chk_irq(1'b1, "b_irq_on", 1'b1);
    chk_reg(1'b1, 2'd2, "b_mask_width", 32'h0000_0003);
    chk_reg(1'b1, 2'd1, "b_addr1", 32'h0);
    chk_reg(1'b0, 2'd2, "a_mask_untouched", 32'h0);
    bus_write(1'b1, 2'd3, 32'hFFFF_FFFF);
    chk_irq(1'b1, "b_irq_off", 1'b0);

    // Reset mid-debounce, then the held pins are debounced afresh.
    in_a = 4'h8; repeat (2) tick();
    reset_n = 1'b0; tick();
    chk_reg(1'b0, 2'd0, "mr_data", 32'h0000_000F);
    chk_reg(1'b0, 2'd3, "mr_cap",  32'h0);
    reset_n = 1'b1;
    repeat (LAT) tick();
    chk_reg(1'b0, 2'd0, "mr_hold", 32'h0000_000F);
    tick();
    chk_reg(1'b0, 2'd0, "mr_after_data", 32'h0000_0008);
    chk_reg(1'b0, 2'd3, "mr_after_cap",  32'h0000_0007);
    chk_irq(1'b0, "mr_irq_masked", 1'b0);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
